traffic_timebase: RTL and testbench
===================================

// Module: traffic_timebase
// PURPOSE
//  Timing and request front-end for the traffic light controller FSM.
//  - Derives 1 s / 10 s elapsed-time strobes from the system clock.
//  - Restarts timing whenever the controller asserts reset_counter.
//  - Synchronises, debounces and latches the raw pedestrian push-button into a clean request level.
//  - Sits between the board clock/button and the controller's pulse_1s, pulse_10s and pedestrian inputs.
// PARAMETERS
//  CLK_HZ       50_000_000  clk frequency; prescaler terminal count = CLK_HZ-1 (>=2)
//  SHORT_SEC    1           seconds since last clear at which pulse_1s fires (1..255)
//  LONG_SEC     10          seconds since last clear at which pulse_10s fires (1..255, > SHORT_SEC)
//  DEBOUNCE_CYC 1_000_000   cycles the synchronised button must be stable to be accepted (>=1)
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  rst            in   1  asynchronous, active-high reset
//  reset_counter  in   1  synchronous restart of elapsed time (from controller)
//  ped_btn_n      in   1  raw pedestrian button, active-low, asynchronous to clk
//  ped_ack        in   1  clears pending pedestrian request (level, sampled each edge)
//  pulse_1s       out  1  1-cycle strobe: SHORT_SEC seconds elapsed since last clear
//  pulse_10s      out  1  1-cycle strobe: LONG_SEC seconds elapsed since last clear
//  pedestrian     out  1  latched, debounced pedestrian request
//  sec_count      out  8  whole seconds elapsed since last clear, saturating
// BEHAVIOUR
//  Reset: rst=1 clears all registers.
//   - Outputs: pulse_1s=0, pulse_10s=0, pedestrian=0, sec_count=0.
//   - Internals: prescaler=0, debounced button state = released (1), sync flops = 1.
//  Prescaler: width $clog2(CLK_HZ).
//   - Increments every cycle; wraps CLK_HZ-1 -> 0.
//   - sec_tick is asserted internally while prescaler==CLK_HZ-1.
//  sec_count:
//   - On sec_tick, increments by 1; saturates at 255 (no wrap).
//  Strobes (registered):
//   - pulse_1s <= sec_tick & (sec_count+1 == SHORT_SEC); otherwise 0.
//   - pulse_10s <= sec_tick & (sec_count+1 == LONG_SEC); otherwise 0.
//   - Each strobe fires at most once per clear interval and is high for exactly 1 cycle.
//   - After saturation no further strobes occur until a clear.
//  reset_counter=1 at an edge:
//   - Sets prescaler, sec_count, pulse_1s and pulse_10s to 0.
//   - Takes priority over a coincident sec_tick; that tick is discarded.
//   - Latency: the first pulse_1s is high exactly CLK_HZ*SHORT_SEC cycles after the clearing edge.
//   - Held high continuously, timing stays frozen at 0.
//  Pedestrian path:
//   - ped_btn_n passes through a 2-flop synchroniser.
//   - A debounce counter restarts whenever the synchronised value differs from the debounced state.
//   - After DEBOUNCE_CYC consecutive differing cycles, the debounced state adopts the new value.
//   - A debounced 1->0 transition (press) is a press event.
//   - Press event sets pedestrian=1 on the same edge as the debounced update.
//   - ped_ack=1 clears pedestrian.
//   - Press event and ped_ack on the same edge: pedestrian=1 (set wins, request not lost).
//   - Holding the button produces only one press event; release produces none.
//   - Glitches shorter than DEBOUNCE_CYC cycles are ignored.
//   - Pedestrian path is independent of reset_counter.
//  Mid-operation rst: immediate asynchronous return to reset values; any in-flight debounce is abandoned.
// TESTING (sim with CLK_HZ=10, SHORT_SEC=1, LONG_SEC=3, DEBOUNCE_CYC=4)
//  1. Release rst, no clear:
//     - pulse_1s high only at cycle 10; pulse_10s high only at cycle 30.
//     - sec_count reads 1, 2, 3 at cycles 10, 20, 30.
//  2. Free-run to 2560 cycles:
//     - sec_count saturates at 255.
//     - No strobes after cycle 30.
//  3. Pulse reset_counter at cycle 25:
//     - pulse_10s does not fire at cycle 30.
//     - pulse_1s fires at cycle 35; pulse_10s fires at cycle 55.
//  4. reset_counter asserted in the same cycle as sec_tick (prescaler=9):
//     - No increment and no strobe; sec_count=0 next cycle.
//  5. Button behaviour:
//     - 3-cycle low glitch on ped_btn_n -> pedestrian stays 0.
//     - 6-cycle press -> pedestrian=1 at 2+4 cycles after the falling input; stays 1 after release.
//     - 1-cycle ped_ack -> pedestrian=0.
//  6. Edge cases:
//     - Debounced press coincident with ped_ack -> pedestrian=1.
//     - Assert rst mid-second -> all outputs 0 immediately.
//     - After rst, pulse_1s fires 10 cycles after rst release.

Source files
------------

// File: rtl/traffic_timebase.sv
// traffic_timebase: second/strobe timebase and debounced pedestrian request for the traffic light controller.
module traffic_timebase #(
   parameter int CLK_HZ       = 50_000_000,
   parameter int SHORT_SEC    = 1,
   parameter int LONG_SEC     = 10,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       reset_counter,
   input  logic       ped_btn_n,
   input  logic       ped_ack,
   output logic       pulse_1s,
   output logic       pulse_10s,
   output logic       pedestrian,
   output logic [7:0] sec_count
);
   localparam int PW = $clog2(CLK_HZ);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
   // Strobe fires when the count is one short of the target and a tick arrives.
   localparam logic [7:0] SHORT_M1 = 8'(SHORT_SEC - 1);
   localparam logic [7:0] LONG_M1 = 8'(LONG_SEC - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    sec_q, sec_d;
   logic          p1_q, p1_d, p10_q, p10_d;
   logic          s1_q, s2_q, db_q, db_d, ped_q, ped_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sec_tick, db_hit, press;

   always_comb begin
      sec_tick = presc_q == P_LAST;
      presc_d  = (reset_counter || sec_tick) ? '0 : presc_q + 1'b1;
      sec_d    = reset_counter ? '0 : (sec_tick && sec_q != 8'hFF) ? sec_q + 8'd1 : sec_q;
      p1_d     = !reset_counter && sec_tick && sec_q == SHORT_M1;
      p10_d    = !reset_counter && sec_tick && sec_q == LONG_M1;
      db_hit   = (s2_q != db_q) && cnt_q == DB_LAST;
      cnt_d    = (s2_q != db_q && !db_hit) ? cnt_q + 1'b1 : '0;
      db_d     = db_hit ? s2_q : db_q;
      press    = db_hit && db_q && !s2_q;
      ped_d    = press || (ped_q && !ped_ack);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         presc_q <= '0;
         sec_q   <= '0;
         p1_q    <= 1'b0;
         p10_q   <= 1'b0;
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         db_q    <= 1'b1;
         cnt_q   <= '0;
         ped_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         sec_q   <= sec_d;
         p1_q    <= p1_d;
         p10_q   <= p10_d;
         s1_q    <= ped_btn_n;
         s2_q    <= s1_q;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
         ped_q   <= ped_d;
      end

   assign pulse_1s   = p1_q;
   assign pulse_10s  = p10_q;
   assign pedestrian = ped_q;
   assign sec_count  = sec_q;
endmodule

// File: tb/tb_traffic_timebase.sv
// tb_traffic_timebase: directed checks of the timebase strobes, clear behaviour and pedestrian debounce.
module tb_traffic_timebase;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       reset_counter = 1'b0;
   logic       ped_btn_n = 1'b1;
   logic       ped_ack = 1'b0;
   logic       pulse_1s, pulse_10s, pedestrian;
   logic [7:0] sec_count;
   int         n_cmp = 0;
   int         n_bad = 0;

   traffic_timebase #(.CLK_HZ(10), .SHORT_SEC(1), .LONG_SEC(3), .DEBOUNCE_CYC(4)) dut (
      .clk(clk), .rst(rst), .reset_counter(reset_counter), .ped_btn_n(ped_btn_n),
      .ped_ack(ped_ack), .pulse_1s(pulse_1s), .pulse_10s(pulse_10s),
      .pedestrian(pedestrian), .sec_count(sec_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if ({pulse_1s, pulse_10s, pedestrian, sec_count} !== 11'd0) begin n_bad++; $display("FAIL reset_outputs got %b exp 0", {pulse_1s, pulse_10s, pedestrian, sec_count}); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_timing();
      for (int c = 1; c <= 30; c++) begin
         tick();
         n_cmp++; if (pulse_1s !== (c == 10)) begin n_bad++; $display("FAIL timing_p1 c=%0d got %b exp %b", c, pulse_1s, c == 10); end
         n_cmp++; if (pulse_10s !== (c == 30)) begin n_bad++; $display("FAIL timing_p10 c=%0d got %b exp %b", c, pulse_10s, c == 30); end
         if (c % 10 == 0) begin
            n_cmp++; if (sec_count !== 8'(c / 10)) begin n_bad++; $display("FAIL timing_sec c=%0d got %0d exp %0d", c, sec_count, c / 10); end
         end
      end
   endtask

   task automatic test_saturation();
      int strobes = 0;
      for (int c = 31; c <= 2560; c++) begin
         tick();
         if (pulse_1s || pulse_10s) strobes++;
         if (c == 2549) begin
            n_cmp++; if (sec_count !== 8'd254) begin n_bad++; $display("FAIL sat_pre got %0d exp 254", sec_count); end
         end
      end
      n_cmp++; if (sec_count !== 8'd255) begin n_bad++; $display("FAIL sat_value got %0d exp 255", sec_count); end
      n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL sat_strobes got %0d exp 0", strobes); end
   endtask

   task automatic test_clear();
      do_reset();
      for (int c = 1; c <= 60; c++) begin
         reset_counter = (c == 25);
         tick();
         n_cmp++; if (pulse_1s !== (c == 10 || c == 35)) begin n_bad++; $display("FAIL clear_p1 c=%0d got %b exp %b", c, pulse_1s, c == 10 || c == 35); end
         n_cmp++; if (pulse_10s !== (c == 55)) begin n_bad++; $display("FAIL clear_p10 c=%0d got %b exp %b", c, pulse_10s, c == 55); end
         if (c == 25) begin
            n_cmp++; if (sec_count !== 8'd0) begin n_bad++; $display("FAIL clear_sec got %0d exp 0", sec_count); end
         end
      end
      reset_counter = 1'b0;
   endtask

   task automatic test_tick_clear();
      int strobes = 0;
      do_reset();
      repeat (9) tick();
      reset_counter = 1'b1;
      tick();
      n_cmp++; if (sec_count !== 8'd0 || pulse_1s !== 1'b0) begin n_bad++; $display("FAIL tickclr got sec=%0d p1=%b exp sec=0 p1=0", sec_count, pulse_1s); end
      repeat (25) begin
         tick();
         if (pulse_1s || pulse_10s || sec_count != 0) strobes++;
      end
      n_cmp++; if (strobes !== 0) begin n_bad++; $display("FAIL held_clear got %0d active cycles exp 0", strobes); end
      reset_counter = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         n_cmp++; if (pulse_1s !== (c == 10)) begin n_bad++; $display("FAIL tickclr_p1 c=%0d got %b exp %b", c, pulse_1s, c == 10); end
      end
   endtask

   task automatic test_button();
      ped_btn_n = 1'b0;
      repeat (3) tick();
      ped_btn_n = 1'b1;
      repeat (10) tick();
      n_cmp++; if (pedestrian !== 1'b0) begin n_bad++; $display("FAIL glitch got %b exp 0", pedestrian); end
      ped_btn_n = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c >= 5) begin
            n_cmp++; if (pedestrian !== (c == 6)) begin n_bad++; $display("FAIL press c=%0d got %b exp %b", c, pedestrian, c == 6); end
         end
      end
      ped_btn_n = 1'b1;
      repeat (10) tick();
      n_cmp++; if (pedestrian !== 1'b1) begin n_bad++; $display("FAIL press_latched got %b exp 1", pedestrian); end
      ped_ack = 1'b1;
      tick();
      ped_ack = 1'b0;
      n_cmp++; if (pedestrian !== 1'b0) begin n_bad++; $display("FAIL ack got %b exp 0", pedestrian); end
      ped_btn_n = 1'b0;
      repeat (6) tick();
      n_cmp++; if (pedestrian !== 1'b1) begin n_bad++; $display("FAIL hold_press got %b exp 1", pedestrian); end
      ped_ack = 1'b1;
      tick();
      ped_ack = 1'b0;
      repeat (12) tick();
      n_cmp++; if (pedestrian !== 1'b0) begin n_bad++; $display("FAIL hold_single got %b exp 0", pedestrian); end
      ped_btn_n = 1'b1;
      repeat (10) tick();
      n_cmp++; if (pedestrian !== 1'b0) begin n_bad++; $display("FAIL release got %b exp 0", pedestrian); end
   endtask

   task automatic test_edges();
      ped_btn_n = 1'b0;
      repeat (5) tick();
      ped_ack = 1'b1;
      tick();
      ped_ack = 1'b0;
      n_cmp++; if (pedestrian !== 1'b1) begin n_bad++; $display("FAIL press_vs_ack got %b exp 1", pedestrian); end
      ped_btn_n = 1'b1;
      repeat (10) tick();
      do_reset();
      repeat (15) tick();
      n_cmp++; if (sec_count !== 8'd1) begin n_bad++; $display("FAIL pre_rst_sec got %0d exp 1", sec_count); end
      rst = 1'b1;
      #1;
      n_cmp++; if ({pulse_1s, pulse_10s, pedestrian, sec_count} !== 11'd0) begin n_bad++; $display("FAIL async_rst got %b exp 0", {pulse_1s, pulse_10s, pedestrian, sec_count}); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         n_cmp++; if (pulse_1s !== (c == 10)) begin n_bad++; $display("FAIL post_rst_p1 c=%0d got %b exp %b", c, pulse_1s, c == 10); end
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_saturation();
      test_clear();
      test_tick_clear();
      test_button();
      test_edges();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
